// File: rtl/alu_result_fifo_if.sv
// Handshake and data bundle for alu_result_fifo.
// slave  : FIFO side (accepts upstream ALU results, presents head entry).
// master : environment side (drives upstream results and downstream ready).
// Signals: i_VALID/o_READY/i_Y/i_OVF/i_ERR upstream, o_VALID/i_READY/o_Y/
// o_OVF/o_ERR downstream, o_COUNT/o_FULL/o_EMPTY occupancy status.
// ALU_RESULT_STATS_EN adds i_CNT_CLR, o_OVF_CNT and o_ERR_CNT.
interface alu_result_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_VALID;
  logic             o_READY;
  logic [WIDTH-1:0] i_Y;
  logic             i_OVF;
  logic             i_ERR;
  logic             o_VALID;
  logic             i_READY;
  logic [WIDTH-1:0] o_Y;
  logic             o_OVF;
  logic             o_ERR;
  logic [CW-1:0]    o_COUNT;
  logic             o_FULL;
  logic             o_EMPTY;
`ifdef ALU_RESULT_STATS_EN
  logic             i_CNT_CLR;
  logic [7:0]       o_OVF_CNT;
  logic [7:0]       o_ERR_CNT;
`endif

  modport slave (
`ifdef ALU_RESULT_STATS_EN
    input  i_CNT_CLR,
    output o_OVF_CNT, o_ERR_CNT,
`endif
    input  i_VALID, i_Y, i_OVF, i_ERR, i_READY,
    output o_READY, o_VALID, o_Y, o_OVF, o_ERR, o_COUNT, o_FULL, o_EMPTY
  );

  modport master (
`ifdef ALU_RESULT_STATS_EN
    output i_CNT_CLR,
    input  o_OVF_CNT, o_ERR_CNT,
`endif
    output i_VALID, i_Y, i_OVF, i_ERR, i_READY,
    input  o_READY, o_VALID, o_Y, o_OVF, o_ERR, o_COUNT, o_FULL, o_EMPTY
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering ALU results {err, ovf, y}.
// Ports: i_CLK (clock), i_RSTn (async active-low reset),
//        bus (alu_result_fifo_if.slave: upstream/downstream handshake,
//        head entry fields and occupancy status).
// Optional macro ALU_RESULT_STATS_EN adds saturating 8-bit counters of
// accepted writes carrying the overflow / error flags, with a synchronous
// clear (bus.i_CNT_CLR) that wins over a same-cycle increment.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  alu_result_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Full blocks writes even when a read happens in the same cycle.
  assign wr_en = bus.i_VALID && !full;
  assign rd_en = bus.i_READY && !empty;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {bus.i_ERR, bus.i_OVF, bus.i_Y};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status comes only from registered state; head reads straight from storage.
  assign bus.o_READY = !full;
  assign bus.o_VALID = !empty;
  assign bus.o_FULL  = full;
  assign bus.o_EMPTY = empty;
  assign bus.o_COUNT = count;
  assign {bus.o_ERR, bus.o_OVF, bus.o_Y} = mem[rd_ptr];

`ifdef ALU_RESULT_STATS_EN
  logic [7:0] ovf_cnt;
  logic [7:0] err_cnt;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      ovf_cnt <= '0;
      err_cnt <= '0;
    end else if (bus.i_CNT_CLR) begin
      ovf_cnt <= '0;
      err_cnt <= '0;
    end else if (wr_en) begin
      if (bus.i_OVF && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (bus.i_ERR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.o_OVF_CNT = ovf_cnt;
  assign bus.o_ERR_CNT = err_cnt;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [WIDTH+1:0] entry_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  entry_t q[$];
  int     m_ovf_cnt;
  int     m_err_cnt;

  alu_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected status vector {valid, ready, full, empty, count} from model queue.
  function automatic logic [CW+3:0] exp_status();
    int n = q.size();
    return {n > 0, n < DEPTH, n == DEPTH, n == 0, CW'(n)};
  endfunction

  function automatic logic [CW+3:0] dut_status();
    return {bus.o_VALID, bus.o_READY, bus.o_FULL, bus.o_EMPTY, bus.o_COUNT};
  endfunction

  // Drive one clock cycle (called at a negedge, returns at the next negedge)
  // and advance the reference model by the FIFO rules.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] y, input bit ovf,
                       input bit err, input bit rdy, input bit clr = 1'b0);
    bit wr, rd;
    bus.i_VALID = v;
    bus.i_Y     = y;
    bus.i_OVF   = ovf;
    bus.i_ERR   = err;
    bus.i_READY = rdy;
`ifdef ALU_RESULT_STATS_EN
    bus.i_CNT_CLR = clr;
`endif
    wr = v && (q.size() < DEPTH);
    rd = rdy && (q.size() > 0);
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back({err, ovf, y});
    if (clr) begin
      m_ovf_cnt = 0;
      m_err_cnt = 0;
    end else if (wr) begin
      if (ovf && m_ovf_cnt < 255) m_ovf_cnt++;
      if (err && m_err_cnt < 255) m_err_cnt++;
    end
    @(negedge clk);
    bus.i_VALID = 1'b0;
    bus.i_READY = 1'b0;
`ifdef ALU_RESULT_STATS_EN
    bus.i_CNT_CLR = 1'b0;
`endif
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(0, '0, 0, 0, 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_VALID = 1'b1;
    bus.i_READY = 1'b1;
    bus.i_Y = 4'hF; bus.i_OVF = 1'b1; bus.i_ERR = 1'b1;
`ifdef ALU_RESULT_STATS_EN
    bus.i_CNT_CLR = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_status() !== {1'b0, 1'b1, 1'b0, 1'b1, CW'(0)}) begin
      n_err++;
      $display("FAIL reset_status: got %b want %b", dut_status(),
               {1'b0, 1'b1, 1'b0, 1'b1, CW'(0)});
    end
    n_cmp++;
    if ({bus.o_ERR, bus.o_OVF, bus.o_Y} !== '0) begin
      n_err++;
      $display("FAIL reset_head: got %h want 0", {bus.o_ERR, bus.o_OVF, bus.o_Y});
    end
    bus.i_VALID = 1'b0;
    bus.i_READY = 1'b0;
    q.delete();
    m_ovf_cnt = 0;
    m_err_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    cycle(1, 4'h5, 1, 0, 0);
    n_cmp++;
    if ({bus.o_VALID, bus.o_Y, bus.o_OVF, bus.o_ERR, bus.o_COUNT} !==
        {1'b1, 4'h5, 1'b1, 1'b0, CW'(1)}) begin
      n_err++;
      $display("FAIL single_write: got v=%b y=%h ovf=%b err=%b cnt=%0d want v=1 y=5 ovf=1 err=0 cnt=1",
               bus.o_VALID, bus.o_Y, bus.o_OVF, bus.o_ERR, bus.o_COUNT);
    end
    // Head must hold while downstream stalls.
    cycle(0, 4'h9, 0, 1, 0);
    n_cmp++;
    if ({bus.o_Y, bus.o_OVF} !== {4'h5, 1'b1}) begin
      n_err++;
      $display("FAIL hold_head: got y=%h ovf=%b want y=5 ovf=1", bus.o_Y, bus.o_OVF);
    end
    drain();
    n_cmp++;
    if (dut_status() !== exp_status()) begin
      n_err++;
      $display("FAIL single_drain: got %b want %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 4'(i), 0, 0, 0);
      if (i == 4) begin
        n_cmp++;
        if ({bus.o_FULL, bus.o_READY} !== 2'b10) begin
          n_err++;
          $display("FAIL fill_full_after4: got full=%b ready=%b want full=1 ready=0",
                   bus.o_FULL, bus.o_READY);
        end
      end
    end
    n_cmp++;
    if (bus.o_COUNT !== CW'(4)) begin
      n_err++;
      $display("FAIL fill_count: got %0d want 4", bus.o_COUNT);
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (bus.o_Y !== 4'(i)) begin
        n_err++;
        $display("FAIL fill_read%0d: got %h want %h", i, bus.o_Y, 4'(i));
      end
      cycle(0, '0, 0, 0, 1);
    end
    n_cmp++;
    if (bus.o_EMPTY !== 1'b1 || bus.o_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL fill_empty: got empty=%b valid=%b want empty=1 valid=0",
               bus.o_EMPTY, bus.o_VALID);
    end
    // Read while empty is ignored.
    cycle(0, '0, 0, 0, 1);
    n_cmp++;
    if (bus.o_COUNT !== CW'(0)) begin
      n_err++;
      $display("FAIL empty_read: got count %0d want 0", bus.o_COUNT);
    end
  endtask

  task automatic test_streaming();
    cycle(1, 4'hA, 0, 0, 0);
    cycle(1, 4'hB, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (bus.o_Y !== ((k < 2) ? 4'(10 + k) : 4'(k - 2))) begin
        n_err++;
        $display("FAIL stream_head%0d: got %h want %h", k, bus.o_Y,
                 (k < 2) ? 4'(10 + k) : 4'(k - 2));
      end
      cycle(1, 4'(k), 0, 0, 1);
      n_cmp++;
      if (bus.o_COUNT !== CW'(2)) begin
        n_err++;
        $display("FAIL stream_count%0d: got %0d want 2", k, bus.o_COUNT);
      end
    end
    drain();
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) cycle(1, 4'(i + 3), 0, 0, 0);
    cycle(1, 4'hE, 1, 1, 1);
    n_cmp++;
    if ({bus.o_COUNT, bus.o_READY, bus.o_Y} !== {CW'(3), 1'b1, 4'h4}) begin
      n_err++;
      $display("FAIL full_rw: got cnt=%0d ready=%b y=%h want cnt=3 ready=1 y=4",
               bus.o_COUNT, bus.o_READY, bus.o_Y);
    end
    n_cmp++;
    if (q[q.size()-1] !== entry_t'({1'b0, 1'b0, 4'h6}) || dut_status() !== exp_status()) begin
      n_err++;
      $display("FAIL full_rw_model: got %b want %b", dut_status(), exp_status());
    end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1, 4'(i + 9), 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf_cnt = 0;
    m_err_cnt = 0;
    n_cmp++;
    if ({bus.o_VALID, bus.o_COUNT, bus.o_Y, bus.o_OVF, bus.o_ERR, bus.o_EMPTY, bus.o_READY} !==
        {1'b0, CW'(0), 4'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got v=%b cnt=%0d y=%h ovf=%b err=%b empty=%b ready=%b want 0 0 0 0 0 1 1",
               bus.o_VALID, bus.o_COUNT, bus.o_Y, bus.o_OVF, bus.o_ERR, bus.o_EMPTY, bus.o_READY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1, 4'h7, 0, 0, 0);
    n_cmp++;
    if ({bus.o_VALID, bus.o_COUNT, bus.o_Y} !== {1'b1, CW'(1), 4'h7}) begin
      n_err++;
      $display("FAIL post_reset_write: got v=%b cnt=%0d y=%h want v=1 cnt=1 y=7",
               bus.o_VALID, bus.o_COUNT, bus.o_Y);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? (k % 64 < 40) : 1'b0);
      n_cmp++;
      if (dut_status() !== exp_status()) begin
        n_err++;
        $display("FAIL rand_status%0d: got %b want %b", k, dut_status(), exp_status());
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({bus.o_ERR, bus.o_OVF, bus.o_Y} !== q[0]) begin
          n_err++;
          $display("FAIL rand_head%0d: got %h want %h", k,
                   {bus.o_ERR, bus.o_OVF, bus.o_Y}, q[0]);
        end
      end
    end
    drain();
  endtask

`ifdef ALU_RESULT_STATS_EN
  task automatic test_stats();
    for (int k = 0; k < 300; k++) cycle(1, 4'(k), k[0], 1, 1);
    n_cmp++;
    if ({bus.o_ERR_CNT, bus.o_OVF_CNT} !== {8'(m_err_cnt), 8'(m_ovf_cnt)} ||
        m_err_cnt != 255) begin
      n_err++;
      $display("FAIL stats_sat: got err=%0d ovf=%0d want err=%0d ovf=%0d",
               bus.o_ERR_CNT, bus.o_OVF_CNT, m_err_cnt, m_ovf_cnt);
    end
    cycle(1, 4'h1, 1, 1, 1, 1);
    n_cmp++;
    if ({bus.o_ERR_CNT, bus.o_OVF_CNT} !== 16'h0000) begin
      n_err++;
      $display("FAIL stats_clr: got err=%0d ovf=%0d want 0 0",
               bus.o_ERR_CNT, bus.o_OVF_CNT);
    end
    cycle(1, 4'h2, 1, 0, 1);
    n_cmp++;
    if ({bus.o_ERR_CNT, bus.o_OVF_CNT} !== {8'd0, 8'd1}) begin
      n_err++;
      $display("FAIL stats_inc: got err=%0d ovf=%0d want 0 1",
               bus.o_ERR_CNT, bus.o_OVF_CNT);
    end
    drain();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.i_VALID = 1'b0;
    bus.i_READY = 1'b0;
    bus.i_Y = '0;
    bus.i_OVF = 1'b0;
    bus.i_ERR = 1'b0;
    test_reset();
    test_single_write();
    test_fill_full();
    test_streaming();
    test_full_rw();
    test_async_reset();
    test_random();
`ifdef ALU_RESULT_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
